// File: rtl/inst_fetch_port.sv
// Instruction fetch port: turns the current PC into one SRAM-like read at a time
// and holds the returned word at the IF/ID boundary until decode accepts it.
module inst_fetch_port #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    input  logic              out_ready,
    output logic              pc_en,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic [DATA_W-1:0] inst_rdata,
    input  logic              inst_data_ok,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_adel
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t              state_q, state_d;
    logic                discard_q, discard_d;
    logic                inst_req_q, inst_req_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic                inst_valid_q, inst_valid_d;
    logic [DATA_W-1:0]   inst_out_q, inst_out_d;
    logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
    logic                inst_adel_q, inst_adel_d;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        discard_d    = discard_q;
        inst_req_d   = inst_req_q;
        req_addr_d   = req_addr_q;
        inst_valid_d = inst_valid_q;
        inst_out_d   = inst_out_q;
        inst_pc_d    = inst_pc_q;
        inst_adel_d  = inst_adel_q;

        unique case (state_q)
            IDLE: begin
                if (fetch_en && !flush) begin
                    req_addr_d = pc;
                    inst_pc_d  = pc;
                    if (pc[1:0] != 2'b00) begin
                        // Misaligned PC never reaches the bus; the error travels down as an instruction.
                        inst_adel_d  = 1'b1;
                        inst_out_d   = '0;
                        inst_valid_d = 1'b1;
                        state_d      = HOLD;
                    end else begin
                        inst_adel_d = 1'b0;
                        inst_req_d  = 1'b1;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                if (flush) discard_d = 1'b1;
                if (inst_addr_ok) begin
                    inst_req_d = 1'b0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (flush) discard_d = 1'b1;
                if (inst_data_ok) begin
                    // A redirect landing on the data beat also kills the word, since pc_en fires now.
                    if (discard_q || flush) begin
                        discard_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        inst_out_d   = inst_rdata;
                        inst_adel_d  = 1'b0;
                        inst_valid_d = 1'b1;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (flush || out_ready) begin
                    inst_valid_d = 1'b0;
                    inst_adel_d  = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            discard_q    <= 1'b0;
            inst_req_q   <= 1'b0;
            req_addr_q   <= '0;
            inst_valid_q <= 1'b0;
            inst_out_q   <= '0;
            inst_pc_q    <= '0;
            inst_adel_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            discard_q    <= discard_d;
            inst_req_q   <= inst_req_d;
            req_addr_q   <= req_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
            inst_adel_q  <= inst_adel_d;
        end
    end

    assign pc_en      = ((state_q == HOLD) && inst_valid_q && out_ready) || flush;
    assign inst_req   = inst_req_q;
    assign inst_addr  = req_addr_q;
    assign inst_valid = inst_valid_q;
    assign inst_out   = inst_out_q;
    assign inst_pc    = inst_pc_q;
    assign inst_adel  = inst_adel_q;

endmodule

// File: tb/tb_inst_fetch_port.sv
// Bench for inst_fetch_port: models the PC register, an instruction memory
// responder with programmable latency, and the architectural delivery stream.
module tb_inst_fetch_port;

    localparam logic [31:0] RESET_PC = 32'hbfc00000;
    localparam logic [31:0] REDIR_PC = 32'hbfc00380;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] pc = RESET_PC;
    logic        pc_en;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic        inst_data_ok = 1'b0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_adel;

    inst_fetch_port #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_en     (fetch_en),
        .pc           (pc),
        .flush        (flush),
        .out_ready    (out_ready),
        .pc_en        (pc_en),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_rdata   (inst_rdata),
        .inst_data_ok (inst_data_ok),
        .inst_valid   (inst_valid),
        .inst_out     (inst_out),
        .inst_pc      (inst_pc),
        .inst_adel    (inst_adel)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Bus responder state
    int          addr_dly = 0;
    int          data_dly = 1;
    int          req_cnt  = 0;
    int          data_cnt = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    bit          force_on = 1'b0;
    logic [31:0] force_word = '0;

    // Architectural model: PC of the next instruction decode should receive
    logic [31:0] arch_pc = RESET_PC;
    bit          pc_en_prev = 1'b0;
    bit          flush_prev = 1'b0;
    logic [31:0] tgt_prev = '0;
    bit          req_hold = 1'b0;
    logic [31:0] req_hold_addr = '0;
    int          quiet = 0;
    int          n_dlv = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RESET_PC) return 32'h3c1d0001;
        return {a[15:0], ~a[31:16]} ^ 32'h13579bdf;
    endfunction

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        t = $urandom & 32'hfffffffc;
        if ($urandom_range(0, 7) == 0) t[1] = 1'b1;
        return t;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: update PC register, run responder, apply inputs, score.
    task automatic step(input bit fl, input bit rdy, input bit en = 1'b1,
                        input logic [31:0] tgt = REDIR_PC);
        bit dlv;
        @(negedge clk);
        if (pc_en_prev) pc = flush_prev ? tgt_prev : pc + 32'd4;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = $urandom;
        if (!rst) begin
            if (pend) begin
                if (data_cnt <= 1) begin
                    inst_data_ok = 1'b1;
                    inst_rdata   = force_on ? force_word : mem_word(pend_addr);
                    pend         = 1'b0;
                end else begin
                    data_cnt--;
                end
            end else if (inst_req) begin
                if (req_cnt >= addr_dly) begin
                    inst_addr_ok = 1'b1;
                    pend         = 1'b1;
                    pend_addr    = inst_addr;
                    data_cnt     = data_dly;
                    req_cnt      = 0;
                end else begin
                    req_cnt++;
                end
            end
        end
        flush     = fl;
        out_ready = rdy;
        fetch_en  = en;
        #1;
        dlv = inst_valid && out_ready && !flush;
        if (dlv) begin
            check("dlv_pc", inst_pc, arch_pc);
            check("dlv_inst", inst_out, (arch_pc[1:0] != 2'b00) ? 32'h0 : mem_word(arch_pc));
            check("dlv_adel", 32'(inst_adel), 32'(arch_pc[1:0] != 2'b00));
            arch_pc = arch_pc + 32'd4;
            n_dlv++;
            quiet = 0;
        end else begin
            quiet++;
        end
        check("pc_en", 32'(pc_en), 32'(dlv || fl));
        if (fl) arch_pc = tgt;
        if (req_hold) check("req_hold", 32'(inst_req && (inst_addr == req_hold_addr)), 32'd1);
        req_hold      = inst_req && !inst_addr_ok;
        req_hold_addr = inst_addr;
        if (inst_addr_ok) check("req_align", 32'(inst_addr[1:0]), 32'd0);
        if (quiet == 150) check("progress", 32'(quiet), 32'd0);
        pc_en_prev = pc_en;
        flush_prev = fl;
        tgt_prev   = tgt;
    endtask

    // Leaves rst deasserted just before a rising edge: the current low phase is cycle 0.
    task automatic do_reset();
        rst          = 1'b1;
        pend         = 1'b0;
        req_cnt      = 0;
        data_cnt     = 0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        pc           = RESET_PC;
        arch_pc      = RESET_PC;
        pc_en_prev   = 1'b0;
        req_hold     = 1'b0;
        quiet        = 0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req"},   32'(inst_req), 32'd0);
        check({tag, "_addr"},  inst_addr, 32'd0);
        check({tag, "_valid"}, 32'(inst_valid), 32'd0);
        check({tag, "_out"},   inst_out, 32'd0);
        check({tag, "_pc"},    inst_pc, 32'd0);
        check({tag, "_adel"},  32'(inst_adel), 32'd0);
        check({tag, "_pc_en"}, 32'(pc_en), 32'd0);
    endtask

    initial begin
        do_reset();
        check_zero("reset");

        // Test 1: minimum latency fetch from the reset vector
        addr_dly = 0;
        data_dly = 1;
        step(1'b0, 1'b1);
        check("t1_req", 32'(inst_req), 32'd1);
        check("t1_addr", inst_addr, RESET_PC);
        step(1'b0, 1'b1);
        check("t1_wait_req", 32'(inst_req), 32'd0);
        check("t1_wait_valid", 32'(inst_valid), 32'd0);
        step(1'b0, 1'b1);
        check("t1_valid", 32'(inst_valid), 32'd1);
        check("t1_out", inst_out, 32'h3c1d0001);
        check("t1_pc", inst_pc, RESET_PC);
        check("t1_pc_en", 32'(pc_en), 32'd1);
        step(1'b0, 1'b1);
        check("t1_idle_valid", 32'(inst_valid), 32'd0);
        check("t1_idle_pc_en", 32'(pc_en), 32'd0);

        // Test 2: back-pressure in HOLD
        step(1'b0, 1'b0);
        check("t2_addr", inst_addr, RESET_PC + 32'd4);
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            check("t2_hold_valid", 32'(inst_valid), 32'd1);
            check("t2_hold_out", inst_out, mem_word(RESET_PC + 32'd4));
            check("t2_hold_req", 32'(inst_req), 32'd0);
        end
        step(1'b0, 1'b1);
        check("t2_release_pc_en", 32'(pc_en), 32'd1);
        step(1'b0, 1'b1);
        check("t2_idle_req", 32'(inst_req), 32'd0);

        // Test 3: bus stalls on both phases
        addr_dly = 3;
        data_dly = 4;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            check("t3_req", 32'(inst_req), 32'd1);
            check("t3_addr", inst_addr, RESET_PC + 32'd8);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            check("t3_wait_valid", 32'(inst_valid), 32'd0);
        end
        step(1'b0, 1'b1);
        check("t3_valid", 32'(inst_valid), 32'd1);
        check("t3_out", inst_out, mem_word(RESET_PC + 32'd8));

        // Test 4: flush while waiting for data; the returned word is dropped
        addr_dly   = 0;
        data_dly   = 3;
        force_on   = 1'b1;
        force_word = 32'hdeadbeef;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("t4_addr", inst_addr, RESET_PC + 32'd12);
        step(1'b1, 1'b1, 1'b1, REDIR_PC);
        check("t4_flush_pc_en", 32'(pc_en), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            check("t4_no_valid", 32'(inst_valid), 32'd0);
            check("t4_no_req", 32'(inst_req), 32'd0);
        end
        force_on = 1'b0;
        data_dly = 1;
        step(1'b0, 1'b1);
        check("t4_redir_req", 32'(inst_req), 32'd1);
        check("t4_redir_addr", inst_addr, REDIR_PC);
        step(1'b0, 1'b1);

        // flush and out_ready together in HOLD: no delivery, redirect to a misaligned PC
        step(1'b1, 1'b1, 1'b1, 32'hbfc00002);
        check("t4_hold_valid", 32'(inst_valid), 32'd1);
        check("t4_hold_pc", inst_pc, REDIR_PC);
        check("t4_flush_wins_pc_en", 32'(pc_en), 32'd1);

        // Test 5: misaligned PC raises adel without a bus request
        step(1'b0, 1'b0);
        check("t5_idle_valid", 32'(inst_valid), 32'd0);
        step(1'b0, 1'b0);
        check("t5_req", 32'(inst_req), 32'd0);
        check("t5_valid", 32'(inst_valid), 32'd1);
        check("t5_adel", 32'(inst_adel), 32'd1);
        check("t5_out", inst_out, 32'd0);
        check("t5_pc", inst_pc, 32'hbfc00002);
        step(1'b0, 1'b1);
        check("t5_pc_en", 32'(pc_en), 32'd1);

        // flush in IDLE: nothing starts that cycle, next IDLE uses the target
        step(1'b1, 1'b0, 1'b1, 32'hbfc00100);
        check("idle_flush_req", 32'(inst_req), 32'd0);
        check("idle_flush_pc_en", 32'(pc_en), 32'd1);
        step(1'b0, 1'b0);
        check("idle_flush_no_fetch", 32'(inst_req), 32'd0);
        data_dly = 3;
        step(1'b0, 1'b0);
        check("idle_flush_addr", inst_addr, 32'hbfc00100);
        check("idle_flush_req2", 32'(inst_req), 32'd1);
        step(1'b0, 1'b0);

        // Test 6: asynchronous reset while waiting for data
        #1;
        rst      = 1'b1;
        pend     = 1'b0;
        req_cnt  = 0;
        data_cnt = 0;
        #1;
        check_zero("async_rst");
        do_reset();
        check("t6_cycle0_valid", 32'(inst_valid), 32'd0);
        addr_dly = 0;
        data_dly = 1;
        step(1'b0, 1'b1);
        check("t6_req", 32'(inst_req), 32'd1);
        check("t6_addr", inst_addr, RESET_PC);
        step(1'b0, 1'b1);
        check("t6_no_stale", 32'(inst_valid), 32'd0);
        step(1'b0, 1'b1);
        check("t6_valid", 32'(inst_valid), 32'd1);
        check("t6_out", inst_out, 32'h3c1d0001);

        // Randomized traffic scored against the architectural delivery stream
        n_dlv = 0;
        for (int i = 0; i < 1500; i++) begin
            addr_dly = $urandom_range(0, 2);
            data_dly = $urandom_range(1, 3);
            step($urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 7) != 0, rand_tgt());
        end
        check("rand_deliveries", 32'(n_dlv >= 50), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
